// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch line buffer.
// Optional per-slot fault reporting is enabled with FETCH_FAULT_EN.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2,
        S_FLUSH = 2'd3
    } fetch_state_t;

    localparam logic [1:0] AXI_BURST_WRAP = 2'd2;
    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
    localparam logic [2:0] FETCH_ARPROT   = 3'h6;
    localparam int         LINE_BYTES     = 64;

    // Beat N of a wrapping burst lands N slots after the critical slot.
    function automatic logic [2:0] wrap_slot(input logic [2:0] base, input logic [2:0] ofs);
        return base + ofs;
    endfunction

endpackage

// File: rtl/fetch_line_store.sv
// 8 x 64-bit line storage with per-slot valid bits (and fault bits when
// FETCH_FAULT_EN is defined); wrap-indexed write, bulk clear, combinational read.
module fetch_line_store (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        wr_en,
    input  logic [2:0]  wr_base,
    input  logic [2:0]  wr_offset,
    input  logic [63:0] wr_data,
`ifdef FETCH_FAULT_EN
    input  logic        wr_fault,
    output logic        rd_fault,
`endif
    input  logic [2:0]  rd_slot,
    output logic [63:0] rd_data,
    output logic        rd_valid
);
    import fetch_pkg::*;

    logic [63:0] data_r [8];
    logic [7:0]  valid_r;
    logic [2:0]  wr_slot_s;

    assign wr_slot_s = wrap_slot(wr_base, wr_offset);

    // Data array; contents are qualified by the valid bits, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_r[wr_slot_s] <= wr_data;
        end
    end

    // Per-slot valid bits.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid_r <= 8'h00;
        end else if (wr_en) begin
            valid_r[wr_slot_s] <= 1'b1;
        end
    end

`ifdef FETCH_FAULT_EN
    logic [7:0] fault_r;

    // Per-slot fault bits captured from the beat response.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            fault_r <= 8'h00;
        end else if (wr_en) begin
            fault_r[wr_slot_s] <= wr_fault;
        end
    end

    assign rd_fault = fault_r[rd_slot];
`endif

    assign rd_data  = data_r[rd_slot];
    assign rd_valid = valid_r[rd_slot];

endmodule

// File: rtl/fetch_line_buffer.sv
// Fetch front end: one critical-word-first AXI wrap burst per line, streamed to
// decode as 32-bit instructions. FETCH_FAULT_EN adds the inst_fault output.
module fetch_line_buffer #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int LINE_BEATS = 8,
    parameter int AXI_ID     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] entry,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
`ifdef FETCH_FAULT_EN
    output logic                  inst_fault,
`endif
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst,
    output logic [ADDR_WIDTH-1:0] inst_pc
);
    import fetch_pkg::*;

    localparam int         LINE_WORDS = LINE_BYTES / 4;
    localparam logic [3:0] LAST_WORD  = 4'(LINE_WORDS - 1);

    fetch_state_t          state_r, state_s;
    logic [ADDR_WIDTH-1:0] pc_r, pc_s, araddr_r;
    logic                  arvalid_r, rready_r, line_end_r, redir_pend_r;
    logic [2:0]            cnt_r;
    logic                  ar_hs_s, r_hs_s, rlast_hs_s, inst_hs_s, end_hs_s;
    logic                  emit_s, fill_wr_s, slot_valid_s;
    logic [63:0]           slot_data_s;
    logic [31:0]           half_s;
    logic                  unused_s;

    assign ar_hs_s    = arvalid_r & m_axi_arready;
    assign r_hs_s     = m_axi_rvalid & rready_r;
    assign rlast_hs_s = r_hs_s & m_axi_rlast;
    assign fill_wr_s  = (state_r == S_FILL) & r_hs_s;

    // Once the last word of the line is consumed mid-fill, pc points into the
    // next line and the stale slots must not be shown to decode.
    assign emit_s     = ((state_r == S_FILL) || (state_r == S_DRAIN)) && slot_valid_s
                        && !line_end_r && !redirect_valid;
    assign inst_hs_s  = emit_s & inst_ready;
    assign end_hs_s   = inst_hs_s && (pc_r[5:2] == LAST_WORD);

    // Next pc: redirect beats consumption.
    always_comb begin
        pc_s = pc_r;
        if (redirect_valid) begin
            pc_s = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        end else if (inst_hs_s) begin
            pc_s = pc_r + ADDR_WIDTH'(4);
        end else begin
            pc_s = pc_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_REQ: begin
                if (ar_hs_s) begin
                    state_s = (redirect_valid || redir_pend_r) ? S_FLUSH : S_FILL;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_FILL: begin
                if (redirect_valid) begin
                    state_s = rlast_hs_s ? S_REQ : S_FLUSH;
                end else if (rlast_hs_s) begin
                    state_s = (line_end_r || end_hs_s) ? S_REQ : S_DRAIN;
                end else begin
                    state_s = S_FILL;
                end
            end
            S_DRAIN: begin
                if (redirect_valid || end_hs_s || !slot_valid_s) begin
                    state_s = S_REQ;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            S_FLUSH: begin
                if (rlast_hs_s) begin
                    state_s = S_REQ;
                end else begin
                    state_s = S_FLUSH;
                end
            end
            default: state_s = S_REQ;
        endcase
    end

    // Control and address registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_REQ;
            pc_r         <= {entry[ADDR_WIDTH-1:2], 2'b00};
            araddr_r     <= {entry[ADDR_WIDTH-1:3], 3'b000};
            arvalid_r    <= 1'b0;
            rready_r     <= 1'b0;
            cnt_r        <= 3'd0;
            line_end_r   <= 1'b0;
            redir_pend_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            arvalid_r <= (state_r == S_REQ) && !ar_hs_s;
            if ((state_s == S_REQ) && (state_r != S_REQ)) begin
                araddr_r <= {pc_s[ADDR_WIDTH-1:3], 3'b000};
            end
            if (ar_hs_s) begin
                rready_r     <= 1'b1;
                cnt_r        <= 3'd0;
                line_end_r   <= 1'b0;
                redir_pend_r <= 1'b0;
            end else begin
                if (rlast_hs_s) begin
                    rready_r <= 1'b0;
                end
                if (fill_wr_s) begin
                    cnt_r <= cnt_r + 3'd1;
                end
                if ((state_r == S_FILL) && end_hs_s) begin
                    line_end_r <= 1'b1;
                end
                if ((state_r == S_REQ) && redirect_valid) begin
                    redir_pend_r <= 1'b1;
                end
            end
        end
    end

`ifdef FETCH_FAULT_EN
    logic slot_fault_s;
    assign unused_s = ^{entry[1:0], redirect_pc[1:0]};
`else
    assign unused_s = ^{entry[1:0], redirect_pc[1:0], m_axi_rresp};
`endif

    fetch_line_store u_store (
        .clk       (clk),
        .reset     (reset),
        .clear     (ar_hs_s),
        .wr_en     (fill_wr_s),
        .wr_base   (araddr_r[5:3]),
        .wr_offset (cnt_r),
        .wr_data   (m_axi_rdata[63:0]),
`ifdef FETCH_FAULT_EN
        .wr_fault  (m_axi_rresp != 2'b00),
        .rd_fault  (slot_fault_s),
`endif
        .rd_slot   (pc_r[5:3]),
        .rd_data   (slot_data_s),
        .rd_valid  (slot_valid_s)
    );

    assign half_s = pc_r[2] ? slot_data_s[63:32] : slot_data_s[31:0];

`ifdef FETCH_FAULT_EN
    assign inst       = slot_fault_s ? 32'h0 : half_s;
    assign inst_fault = emit_s & slot_fault_s;
`else
    assign inst       = half_s;
`endif
    assign inst_valid = emit_s;
    assign inst_pc    = pc_r;

    assign m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign m_axi_araddr  = araddr_r;
    assign m_axi_arlen   = 8'(LINE_BEATS - 1);
    assign m_axi_arsize  = AXI_SIZE_8B;
    assign m_axi_arburst = AXI_BURST_WRAP;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'h0;
    assign m_axi_arprot  = FETCH_ARPROT;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_rready  = rready_r;

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Directed bench for fetch_line_buffer; the fault scenario is built when
// FETCH_FAULT_EN is defined.
module tb_fetch_line_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] entry, redirect_pc;
    logic        redirect_valid;
    logic [12:0] arid;
    logic [63:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic        arvalid, arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic        inst_valid, inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
`ifdef FETCH_FAULT_EN
    logic        inst_fault;
`endif
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_line_buffer dut (
        .clk(clk), .reset(reset), .entry(entry),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
        .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock),
        .m_axi_arcache(arcache), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
`ifdef FETCH_FAULT_EN
        .inst_fault(inst_fault),
`endif
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
    );

    // Slot s of a line holds words 2s (low) and 2s+1 (high) of the pattern.
    function automatic logic [63:0] slot_data(input logic [31:0] pat, input int s);
        return {pat + 32'(2 * s + 1), pat + 32'(2 * s)};
    endfunction

    task automatic do_reset(input logic [63:0] e);
        reset = 1'b1; entry = e; redirect_valid = 1'b0; redirect_pc = 64'h0;
        arready = 1'b0; rvalid = 1'b0; rdata = 64'h0; rresp = 2'b00; rlast = 1'b0;
        inst_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_ar(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arvalid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic ar_accept();
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(64'h1000);
        total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL reset_arvalid got=%0b exp=0", arvalid); end
        total++; if (rready !== 1'b0) begin bad++; $display("FAIL reset_rready got=%0b exp=0", rready); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_inst_valid got=%0b exp=0", inst_valid); end
    endtask

    task automatic test_full_line();
        bit ok;
        int k;
        int b;
        do_reset(64'h1000);
        inst_ready = 1'b1;
        wait_ar(ok);
        total++; if (!ok) begin bad++; $display("FAIL full_ar_timeout got=0 exp=1"); end
        total++;
        if ({araddr, arlen, arsize, arburst, arid, arprot, arlock, arcache} !==
            {64'h1000, 8'd7, 3'd3, 2'd2, 13'd0, 3'd6, 1'b0, 4'd0}) begin
            bad++;
            $display("FAIL full_ar_fields got=%h/%0d/%0d/%0d/%0d/%0d exp=1000/7/3/2/0/6",
                     araddr, arlen, arsize, arburst, arid, arprot);
        end
        ar_accept();
        k = 0; b = 0;
        for (int c = 0; c < 40 && k < 16; c++) begin
            if (inst_valid === 1'b1) begin
                total++;
                if ((inst_pc !== (64'h1000 + 64'(4 * k))) || (inst !== (32'hA000_0000 + 32'(k)))) begin
                    bad++;
                    $display("FAIL full_inst got=%h:%h exp=%h:%h", inst_pc, inst,
                             64'h1000 + 64'(4 * k), 32'hA000_0000 + 32'(k));
                end
                k++;
            end
            if (b < 8) begin
                rvalid = 1'b1; rdata = slot_data(32'hA000_0000, b); rlast = (b == 7); b++;
            end else begin
                rvalid = 1'b0; rlast = 1'b0;
            end
            @(negedge clk);
        end
        rvalid = 1'b0; rlast = 1'b0;
        total++; if (k != 16) begin bad++; $display("FAIL full_inst_count got=%0d exp=16", k); end
        wait_ar(ok);
        total++;
        if (!ok || araddr !== 64'h1040) begin bad++; $display("FAIL full_next_ar got=%h exp=1040", araddr); end
    endtask

    task automatic test_crit_word();
        bit ok;
        do_reset(64'h1038);
        inst_ready = 1'b1;
        wait_ar(ok);
        total++;
        if (!ok || araddr !== 64'h1038) begin bad++; $display("FAIL crit_ar got=%h exp=1038", araddr); end
        ar_accept();
        for (int b = 0; b < 8; b++) begin
            total++;
            if (b == 1) begin
                if ({inst_valid, inst_pc, inst} !== {1'b1, 64'h1038, 32'hC000_000E}) begin
                    bad++; $display("FAIL crit_first got=%0b:%h:%h exp=1:1038:c000000e", inst_valid, inst_pc, inst);
                end
            end else if (b == 2) begin
                if ({inst_valid, inst_pc, inst} !== {1'b1, 64'h103C, 32'hC000_000F}) begin
                    bad++; $display("FAIL crit_second got=%0b:%h:%h exp=1:103c:c000000f", inst_valid, inst_pc, inst);
                end
            end else begin
                if (inst_valid !== 1'b0) begin
                    bad++; $display("FAIL crit_idle b=%0d got=%0b exp=0", b, inst_valid);
                end
            end
            rvalid = 1'b1; rdata = slot_data(32'hC000_0000, (7 + b) % 8); rlast = (b == 7);
            @(negedge clk);
        end
        rvalid = 1'b0; rlast = 1'b0;
        wait_ar(ok);
        total++;
        if (!ok || araddr !== 64'h1040) begin bad++; $display("FAIL crit_next_ar got=%h exp=1040", araddr); end
    endtask

    task automatic test_stall();
        bit ok;
        do_reset(64'h1000);
        wait_ar(ok);
        ar_accept();
        for (int b = 0; b < 8; b++) begin
            rvalid = 1'b1; rdata = slot_data(32'hB000_0000, b); rlast = (b == 7);
            @(negedge clk);
        end
        rvalid = 1'b0; rlast = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({inst_valid, inst_pc} !== {1'b1, 64'h1000 + 64'(4 * i)}) begin
                bad++; $display("FAIL stall_pre got=%0b:%h exp=1:%h", inst_valid, inst_pc, 64'h1000 + 64'(4 * i));
            end
            inst_ready = 1'b1;
            @(negedge clk);
        end
        for (int j = 0; j < 5; j++) begin
            inst_ready = 1'b0;
            total++;
            if ({inst_valid, inst_pc, inst} !== {1'b1, 64'h100C, 32'hB000_0003}) begin
                bad++; $display("FAIL stall_hold j=%0d got=%0b:%h:%h exp=1:100c:b0000003", j, inst_valid, inst_pc, inst);
            end
            if (j == 4) inst_ready = 1'b1;
            @(negedge clk);
        end
        for (int m = 0; m < 12; m++) begin
            total++;
            if ({inst_valid, inst_pc, inst} !== {1'b1, 64'h1010 + 64'(4 * m), 32'hB000_0004 + 32'(m)}) begin
                bad++; $display("FAIL stall_release got=%0b:%h:%h exp=1:%h:%h", inst_valid, inst_pc, inst,
                                64'h1010 + 64'(4 * m), 32'hB000_0004 + 32'(m));
            end
            @(negedge clk);
        end
        wait_ar(ok);
        total++;
        if (!ok || araddr !== 64'h1040) begin bad++; $display("FAIL stall_next_ar got=%h exp=1040", araddr); end
    endtask

    task automatic test_redirect_fill();
        bit ok;
        bit found;
        int b;
        do_reset(64'h1000);
        wait_ar(ok);
        ar_accept();
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                total++;
                if (inst_valid !== 1'b1) begin bad++; $display("FAIL redir_pre_valid got=%0b exp=1", inst_valid); end
                redirect_valid = 1'b1; redirect_pc = 64'h2006;
            end else if (i > 3) begin
                total++;
                if (inst_valid !== 1'b0) begin bad++; $display("FAIL redir_flush_inst i=%0d got=%0b exp=0", i, inst_valid); end
            end
            rvalid = 1'b1; rdata = slot_data(32'hA500_0000, i); rlast = (i == 7);
            if (i == 3) begin
                #1;
                total++;
                if (inst_valid !== 1'b0) begin bad++; $display("FAIL redir_same_cycle got=%0b exp=0", inst_valid); end
            end
            @(negedge clk);
            redirect_valid = 1'b0;
        end
        rvalid = 1'b0; rlast = 1'b0;
        wait_ar(ok);
        total++;
        if (!ok || araddr !== 64'h2000) begin bad++; $display("FAIL redir_ar got=%h exp=2000", araddr); end
        ar_accept();
        inst_ready = 1'b1;
        found = 1'b0; b = 0;
        for (int c = 0; c < 12 && !found; c++) begin
            if (inst_valid === 1'b1) begin
                found = 1'b1;
                total++;
                if ({inst_pc, inst} !== {64'h2004, 32'hD000_0001}) begin
                    bad++; $display("FAIL redir_first_inst got=%h:%h exp=2004:d0000001", inst_pc, inst);
                end
            end
            if (b < 8) begin
                rvalid = 1'b1; rdata = slot_data(32'hD000_0000, b); rlast = (b == 7); b++;
            end else begin
                rvalid = 1'b0; rlast = 1'b0;
            end
            @(negedge clk);
        end
        rvalid = 1'b0; rlast = 1'b0;
        total++; if (!found) begin bad++; $display("FAIL redir_inst_timeout got=0 exp=1"); end
    endtask

    task automatic test_ar_stall();
        bit ok;
        do_reset(64'h1000);
        wait_ar(ok);
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({arvalid, araddr} !== {1'b1, 64'h1000}) begin
                bad++; $display("FAIL arstall_hold i=%0d got=%0b:%h exp=1:1000", i, arvalid, araddr);
            end
            redirect_valid = (i == 1); redirect_pc = 64'h3000;
            @(negedge clk);
        end
        redirect_valid = 1'b0;
        ar_accept();
        total++;
        if ({arvalid, rready} !== 2'b01) begin bad++; $display("FAIL arstall_hs got=%0b%0b exp=01", arvalid, rready); end
        inst_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            total++;
            if (inst_valid !== 1'b0) begin bad++; $display("FAIL arstall_flush b=%0d got=%0b exp=0", b, inst_valid); end
            rvalid = 1'b1; rdata = slot_data(32'hEE00_0000, b); rlast = (b == 7);
            @(negedge clk);
        end
        rvalid = 1'b0; rlast = 1'b0;
        wait_ar(ok);
        total++;
        if (!ok || araddr !== 64'h3000) begin bad++; $display("FAIL arstall_new_ar got=%h exp=3000", araddr); end
        inst_ready = 1'b0;
        ar_accept();
        rvalid = 1'b1; rdata = slot_data(32'h3300_0000, 0); rlast = 1'b0;
        @(negedge clk);
        rvalid = 1'b0;
        total++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 64'h3000, 32'h3300_0000}) begin
            bad++; $display("FAIL arstall_first_inst got=%0b:%h:%h exp=1:3000:33000000", inst_valid, inst_pc, inst);
        end
    endtask

    task automatic test_short_burst();
        bit ok;
        int k;
        do_reset(64'h1000);
        inst_ready = 1'b1;
        wait_ar(ok);
        ar_accept();
        k = 0;
        for (int c = 0; c < 10; c++) begin
            if (inst_valid === 1'b1) begin
                total++;
                if ({inst_pc, inst} !== {64'h1000 + 64'(4 * k), 32'h5000_0000 + 32'(k)}) begin
                    bad++; $display("FAIL short_inst got=%h:%h exp=%h:%h", inst_pc, inst,
                                    64'h1000 + 64'(4 * k), 32'h5000_0000 + 32'(k));
                end
                k++;
            end
            if (c < 3) begin
                rvalid = 1'b1; rdata = slot_data(32'h5000_0000, c); rlast = (c == 2);
            end else begin
                rvalid = 1'b0; rlast = 1'b0;
            end
            @(negedge clk);
        end
        total++; if (k != 6) begin bad++; $display("FAIL short_inst_count got=%0d exp=6", k); end
        wait_ar(ok);
        total++;
        if (!ok || araddr !== 64'h1018) begin bad++; $display("FAIL short_refetch got=%h exp=1018", araddr); end
    endtask

`ifdef FETCH_FAULT_EN
    task automatic test_fault();
        bit ok;
        logic        exp_fault;
        logic [31:0] exp_inst;
        do_reset(64'h1000);
        wait_ar(ok);
        ar_accept();
        for (int b = 0; b < 8; b++) begin
            rvalid = 1'b1; rdata = slot_data(32'hF000_0000, b); rlast = (b == 7);
            rresp = (b == 2) ? 2'b10 : 2'b00;
            @(negedge clk);
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        for (int w = 0; w < 16; w++) begin
            exp_fault = (w == 4) || (w == 5);
            exp_inst  = exp_fault ? 32'h0 : (32'hF000_0000 + 32'(w));
            total++;
            if ({inst_valid, inst_fault, inst_pc, inst} !== {1'b1, exp_fault, 64'h1000 + 64'(4 * w), exp_inst}) begin
                bad++; $display("FAIL fault_inst w=%0d got=%0b%0b:%h:%h exp=1%0b:%h:%h", w, inst_valid, inst_fault,
                                inst_pc, inst, exp_fault, 64'h1000 + 64'(4 * w), exp_inst);
            end
            inst_ready = 1'b1;
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_line();
        test_crit_word();
        test_stall();
        test_redirect_fill();
        test_ar_stall();
        test_short_burst();
`ifdef FETCH_FAULT_EN
        test_fault();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
